// File: rtl/tt_ranword_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tt_ranword_pkg                                             |
// | Description : Shared constants and helpers for the tt_ranword random     |
// |               word assembler (default geometry, drop counter width,      |
// |               pointer-width helper).                                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package tt_ranword_pkg;

  localparam int WIDTH_DEFAULT = 8;
  localparam int DEPTH_DEFAULT = 2;
  localparam int DROP_CNT_W    = 8;

  // Bits needed to index 0..n-1; never less than one so a depth of 1
  // still gets a legal (constant-zero) pointer.
  function automatic int ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tt_ranword_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tt_ranword_fifo                                            |
// | Description : Synchronous DEPTH x WIDTH FIFO. Pointers wrap modulo DEPTH;|
// |               full/empty come from an occupancy count. A push into a     |
// |               full FIFO is taken only when a pop happens on the same     |
// |               edge; a pop on an empty FIFO is ignored.                   |
// | Ports       : clk, rst_n (sync, active-low), push/push_data,            |
// |               pop, head (front word, 0 when empty), full, empty, count.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tt_ranword_fifo
  import tt_ranword_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int PTR_W = ptr_width(DEPTH),
  parameter int CNT_W = ptr_width(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  // Head is forced to zero while empty so the output is clean after reset
  // without having to clear the whole storage array.
  assign head  = empty ? '0 : r_mem[r_rd_ptr];

  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= ptr_next(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= ptr_next(r_rd_ptr);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tt_ranword.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tt_ranword                                                 |
// | Description : Assembles serial random bits (MSB-first) into WIDTH-bit    |
// |               words and buffers them in a small FIFO. Completed words    |
// |               arriving at a full FIFO are dropped and counted; shifting  |
// |               never stalls.                                              |
// | Config      : `define TT_RANWORD_VN_DEBIAS_EN enables a von Neumann      |
// |               debiaser (pairs 01->0, 10->1, 00/11 discarded).            |
// | Ports       : clk, rst_n (sync, active-low), bit_in, bit_valid,         |
// |               word_out, word_valid, word_ready, overflow, drop_count.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tt_ranword
  import tt_ranword_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bit_in,
  input  logic                  bit_valid,
  output logic [WIDTH-1:0]      word_out,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam int BCNT_W = ptr_width(WIDTH);
  localparam int FCNT_W = ptr_width(DEPTH + 1);

  logic              w_feed;
  logic              w_feed_bit;
  logic [WIDTH-1:0]  r_shift;
  logic [BCNT_W-1:0] r_bit_cnt;
  logic              w_word_done;
  logic [WIDTH-1:0]  w_word;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [FCNT_W-1:0] w_count;

`ifdef TT_RANWORD_VN_DEBIAS_EN
  // Pair phase: 0 = waiting for first bit of a pair, 1 = waiting for second.
  logic r_phase;
  logic r_first;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_phase <= 1'b0;
      r_first <= 1'b0;
    end else if (bit_valid) begin
      r_phase <= ~r_phase;
      if (!r_phase) begin
        r_first <= bit_in;
      end
    end
  end

  // Unequal pair emits its first bit on the second bit's edge.
  assign w_feed     = bit_valid && r_phase && (r_first != bit_in);
  assign w_feed_bit = r_first;
`else
  assign w_feed     = bit_valid;
  assign w_feed_bit = bit_in;
`endif

  // The completed word includes the bit being fed this cycle, so it can be
  // pushed on the same edge that the WIDTH-th bit arrives.
  assign w_word      = {r_shift[WIDTH-2:0], w_feed_bit};
  assign w_word_done = w_feed && (r_bit_cnt == BCNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_feed) begin
      r_shift   <= w_word;
      r_bit_cnt <= w_word_done ? '0 : r_bit_cnt + BCNT_W'(1);
    end
  end

  assign w_pop      = word_ready && !w_empty;
  assign word_valid = (w_count != '0);

  tt_ranword_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_word_done),
    .push_data (w_word),
    .pop       (w_pop),
    .head      (word_out),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  // A word is lost only when the FIFO is full and nothing leaves this edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (w_word_done && w_full && !w_pop) begin
      overflow <= 1'b1;
      if (drop_count != {DROP_CNT_W{1'b1}}) begin
        drop_count <= drop_count + DROP_CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tt_ranword.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_tt_ranword                                              |
// | Description : Directed self-checking bench for tt_ranword (WIDTH=8,      |
// |               DEPTH=2). With TT_RANWORD_VN_DEBIAS_EN defined it runs the |
// |               debiaser sequence instead of the plain-path sequence.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_tt_ranword;

  logic       clk;
  logic       rst_n;
  logic       bit_in;
  logic       bit_valid;
  logic [7:0] word_out;
  logic       word_valid;
  logic       word_ready;
  logic       overflow;
  logic [7:0] drop_count;

  int checks = 0;
  int errors = 0;

  tt_ranword #(.WIDTH(8), .DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    bit_in     = 1'b0;
    bit_valid  = 1'b0;
    word_ready = 1'b0;
    #1;
    do_reset();

    chk("rst_valid", {31'd0, word_valid}, 32'd0);
    chk("rst_word",  {24'd0, word_out},   32'd0);
    chk("rst_ovf",   {31'd0, overflow},   32'd0);
    chk("rst_drop",  {24'd0, drop_count}, 32'd0);

`ifdef TT_RANWORD_VN_DEBIAS_EN
    // Pairs 01,10,00,11 repeated: each repetition feeds 0 then 1.
    for (int r = 0; r < 8; r++) begin
      send_bit(1'b0); send_bit(1'b1);
      send_bit(1'b1); send_bit(1'b0);
      send_bit(1'b0); send_bit(1'b0);
      send_bit(1'b1); send_bit(1'b1);
      if (r == 3) chk("vn_first_valid", {31'd0, word_valid}, 32'd1);
    end
    chk("vn_word0", {24'd0, word_out}, 32'h55);
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    chk("vn_word1", {24'd0, word_out}, 32'h55);
    chk("vn_ovf",   {31'd0, overflow}, 32'd0);
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    chk("vn_empty", {31'd0, word_valid}, 32'd0);
`else
    // Basic word 1,0,1,1,0,0,1,0 with consumer ready.
    word_ready = 1'b1;
    send_byte(8'hB2);
    chk("b2_valid", {31'd0, word_valid}, 32'd1);
    chk("b2_word",  {24'd0, word_out},   32'hB2);
    tick();
    chk("b2_popped", {31'd0, word_valid}, 32'd0);
    word_ready = 1'b0;

    // Gapped bits: counter must hold in idle cycles.
    for (int i = 7; i >= 0; i--) begin
      send_bit(logic'((8'h3C >> i) & 8'h01));
      tick();
      if (i == 4) chk("gap_midword", {31'd0, word_valid}, 32'd0);
    end
    chk("gap_valid", {31'd0, word_valid}, 32'd1);
    chk("gap_word",  {24'd0, word_out},   32'h3C);
    do_reset();

    // Fill, then drop one.
    send_byte(8'hA1);
    send_byte(8'h5C);
    send_byte(8'hFF);
    chk("full_head", {24'd0, word_out},   32'hA1);
    chk("full_ovf",  {31'd0, overflow},   32'd1);
    chk("full_drop", {24'd0, drop_count}, 32'd1);

    // Last bit of next word coincides with a pop: no drop, head advances.
    for (int i = 7; i >= 1; i--) send_bit(logic'((8'h0F >> i) & 8'h01));
    word_ready = 1'b1;
    send_bit(1'b1);
    word_ready = 1'b0;
    chk("swap_drop", {24'd0, drop_count}, 32'd1);
    chk("swap_head", {24'd0, word_out},   32'h5C);
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    chk("swap_next", {24'd0, word_out}, 32'h0F);
    chk("swap_cnt2", {31'd0, word_valid}, 32'd1);
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    chk("swap_empty", {31'd0, word_valid}, 32'd0);

    // Saturation: refill, then drop 300 more words (1 already counted).
    send_byte(8'h11);
    send_byte(8'h22);
    for (int w = 0; w < 100; w++) send_byte(8'h33);
    chk("drop_101", {24'd0, drop_count}, 32'h65);
    for (int w = 0; w < 200; w++) send_byte(8'h44);
    chk("drop_sat",  {24'd0, drop_count}, 32'hFF);
    chk("drop_head", {24'd0, word_out},   32'h11);

    // Reset mid-word with a bit presented during reset.
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    rst_n     = 1'b0;
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    tick();
    rst_n     = 1'b1;
    bit_valid = 1'b0;
    chk("mid_rst_ovf",  {31'd0, overflow},   32'd0);
    chk("mid_rst_drop", {24'd0, drop_count}, 32'd0);
    for (int i = 7; i >= 1; i--) send_bit(logic'((8'h5A >> i) & 8'h01));
    chk("mid_rst_early", {31'd0, word_valid}, 32'd0);
    send_bit(1'b0);
    chk("mid_rst_valid", {31'd0, word_valid}, 32'd1);
    chk("mid_rst_word",  {24'd0, word_out},   32'h5A);
    chk("mid_rst_ovf2",  {31'd0, overflow},   32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tt_ranword.md
TT_RANWORD -- requirements
Module: tt_ranword

Interface
REQ-001 Parameter WIDTH, default 8, sets the output word width in bits (legal 2..16).
REQ-002 Parameter DEPTH, default 2, sets the output FIFO depth in words (legal 1..8).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 bit_in  input  1  serial random bit from the upstream 16-bit LFSR stage.
REQ-006 bit_valid  input  1  bit_in qualifier; the bit is consumed on any posedge clk with bit_valid=1 (no backpressure upstream).
REQ-007 word_out  output  WIDTH  FIFO head word.
REQ-008 word_valid  output  1  FIFO not empty.
REQ-009 word_ready  input  1  consumer accepts word_out on a cycle where word_valid=1 and word_ready=1.
REQ-010 overflow  output  1  sticky flag; at least one completed word was dropped.
REQ-011 drop_count  output  8  saturating count of dropped words.

Function
REQ-012 Accepted bits SHALL shift in MSB-first: first accepted bit of a word lands in word_out[WIDTH-1].
REQ-013 Bit counter SHALL run 0..WIDTH-1, hold when no bit is accepted, and wrap to 0 on the WIDTH-th accepted bit.
REQ-014 On the WIDTH-th accepted bit the completed word SHALL be pushed to the FIFO in that same edge; word_valid SHALL rise 1 cycle after that edge when the FIFO was empty.
REQ-015 Pop SHALL occur on word_valid && word_ready; word_out SHALL present the next entry on the following cycle.
REQ-016 Push to a full FIFO with no pop in the same cycle SHALL discard the new word, set overflow, and increment drop_count (saturating at 8'hFF).
REQ-017 Simultaneous push and pop on a full FIFO SHALL perform both; no drop.
REQ-018 Simultaneous push and pop on an empty FIFO is impossible (word_valid=0); the push SHALL simply be taken.
REQ-019 Shifting SHALL never stall: a drop does not affect the bit counter or the next word.
REQ-020 FIFO pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished by an occupancy count.

Reset
REQ-021 On rst_n=0 at posedge clk: bit counter, shift register, FIFO pointers and occupancy, overflow and drop_count SHALL clear to 0; word_valid=0; word_out=0.
REQ-022 Reset mid-word SHALL discard the partial word; the next WIDTH accepted bits form a complete word.
REQ-023 Bits presented during reset SHALL be ignored.

Configuration
REQ-024 Macro TT_RANWORD_VN_DEBIAS_EN compiled in: accepted bits SHALL be taken in pairs (first, second). Pair 01 feeds bit 0 to the shifter, pair 10 feeds bit 1, pairs 00/11 feed nothing, and the feed occurs on the second bit's edge; reset SHALL clear the pair phase.
REQ-025 Macro absent: every accepted bit SHALL feed the shifter directly, with no pairing logic synthesized.

Structure
REQ-026 Package tt_ranword_pkg SHALL hold the WIDTH/DEPTH default constants, the drop_count width constant (8), and the pointer-width function (clog2 of DEPTH, minimum 1).
REQ-027 Sub-module tt_ranword_fifo (synchronous, DEPTH x WIDTH, push/pop/full/empty/count) SHALL hold the buffer; the top holds the shifter, counter, debiaser and drop logic.

Verification (WIDTH=8, DEPTH=2, macro absent unless stated)
REQ-028 Bits 1,0,1,1,0,0,1,0 with bit_valid=1 and word_ready=1 -> word_out=8'hB2 and word_valid=1 on the cycle after the 8th bit, then 0 after the pop.
REQ-029 word_ready=0 with 24 consecutive bits -> 2 words held, 3rd dropped, overflow=1, drop_count=1; 300 words dropped -> drop_count=8'hFF.
REQ-030 FIFO full, 8th bit of the next word coincides with a pop -> occupancy stays 2, drop_count unchanged, head advances.
REQ-031 bit_valid toggled 1/0 every cycle -> word completes after 16 cycles with the correct value; the counter holds in gaps.
REQ-032 rst_n=0 for one cycle after 5 bits, then 8'h5A serialized -> first word_out=8'h5A; overflow=0.
REQ-033 TT_RANWORD_VN_DEBIAS_EN defined, pairs 01,10,00,11 repeated 8 times -> 16 feeds, words 8'h55 then 8'h55; 00/11 pairs contribute nothing.
